// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-phase CPU sequencer: opcodes, ALU op codes and
// FSM state encodings.
package cpu_pkg;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_XOR  = 2'b11;

  typedef enum logic [3:0] {
    S_RST   = 4'd0,
    S_IADDR = 4'd1,
    S_IRD   = 4'd2,
    S_DEC   = 4'd3,
    S_OPRD  = 4'd4,
    S_STO   = 4'd5,
    S_SKZ   = 4'd6,
    S_JMP   = 4'd7,
    S_HALT  = 4'd8
  } state_e;

  // ALU operation used while an operand is read; LDA passes memory data through.
  function automatic logic [1:0] alu_code(input logic [2:0] op);
    logic [1:0] code;
    code = ALU_PASS;
    case (op)
      OP_ADD:  code = ALU_ADD;
      OP_AND:  code = ALU_AND;
      OP_XOR:  code = ALU_XOR;
      default: code = ALU_PASS;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Counts cycles spent waiting for mem_ready in the current phase; flags when the
// count reaches WAIT_MAX. Cleared whenever the sequencer changes state.
module seq_wait_timer #(
  parameter int unsigned WAIT_MAX = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic timeout
);

  localparam int unsigned CntW = $clog2(WAIT_MAX + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign timeout = (cnt_q == CntW'(WAIT_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !timeout) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-phase instruction sequencer for the 8-bit RISC CPU: fetch, decode, operand and
// execute phases with memory handshake, wait timeout, halt/resume and illegal-opcode flag.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned OPCODE_W = 3,
  parameter int unsigned ALU_OP_W = 2,
  parameter int unsigned WAIT_MAX = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                acc_zero,
  input  logic                mem_ready,
  input  logic                resume,
  output logic                stop,
  output logic                err,
  output logic                mem_rd,
  output logic                write_en,
  output logic                load_ir,
  output logic                regWrite,
  output logic                ALUToACC,
  output logic [ALU_OP_W-1:0] ALU_Op,
  output logic                PC_addr,
  output logic                PC_actve,
  output logic                pc_load,
  output logic                skip,
  output logic [3:0]          state_o
);

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic       err_q, err_d;
  logic       timeout, wait_inc, wait_clr;
  logic       legal;

  // Only the low three bits carry an encoding; anything wider must be zero.
  assign legal = ((opcode >> 3) == '0);

  assign wait_clr = (state_d != state_q);
  assign state_o  = state_q;
  assign err      = err_q;

  seq_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (wait_clr),
    .inc    (wait_inc),
    .timeout(timeout)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    err_d    = err_q;
    wait_inc = 1'b0;
    stop     = 1'b0;
    mem_rd   = 1'b0;
    write_en = 1'b0;
    load_ir  = 1'b0;
    regWrite = 1'b0;
    ALUToACC = 1'b0;
    ALU_Op   = '0;
    PC_addr  = 1'b0;
    PC_actve = 1'b0;
    pc_load  = 1'b0;
    skip     = 1'b0;

    unique case (state_q)
      S_RST: state_d = S_IADDR;

      S_IADDR: begin
        PC_addr = 1'b1;
        mem_rd  = 1'b1;
        state_d = S_IRD;
      end

      S_IRD: begin
        PC_addr = 1'b1;
        mem_rd  = 1'b1;
        if (mem_ready) begin
          load_ir = 1'b1;
          state_d = S_DEC;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end

      S_DEC: begin
        PC_actve = 1'b1;
        op_d     = opcode[2:0];
        if (!legal) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          case (opcode[2:0])
            OP_HLT:                         state_d = S_HALT;
            OP_SKZ:                         state_d = S_SKZ;
            OP_ADD, OP_AND, OP_XOR, OP_LDA: state_d = S_OPRD;
            OP_STO:                         state_d = S_STO;
            OP_JMP:                         state_d = S_JMP;
            default:                        state_d = S_HALT;
          endcase
        end
      end

      S_OPRD: begin
        mem_rd   = 1'b1;
        ALU_Op   = ALU_OP_W'(alu_code(op_q));
        ALUToACC = (op_q != OP_LDA);
        if (mem_ready) begin
          regWrite = 1'b1;
          state_d  = S_IADDR;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end

      S_STO: begin
        write_en = 1'b1;
        if (mem_ready) begin
          state_d = S_IADDR;
        end else if (timeout) begin
          // Abandoned store: drop the request on the cycle we give up.
          write_en = 1'b0;
          err_d    = 1'b1;
          state_d  = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end

      S_SKZ: begin
        PC_actve = acc_zero;
        skip     = acc_zero;
        state_d  = S_IADDR;
      end

      S_JMP: begin
        pc_load = 1'b1;
        state_d = S_IADDR;
      end

      S_HALT: begin
        stop = 1'b1;
        if (resume) begin
          state_d = S_IADDR;
        end
      end

      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RST;
      op_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

endmodule
